// File: rtl/apb_timer.sv
//==============================================================================
// Module      : apb_timer
// Description : APB completer with a 32-bit down-counting timer and a
//               programmable number of access-phase wait states.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_timer #(
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    input  logic [2:0]  PPROT,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] PRDATA,
    output logic        IRQ
);

    localparam logic [2:0] c_wait_last  = 3'(WAIT_STATES);
    localparam logic [1:0] c_idx_ctrl   = 2'd0;
    localparam logic [1:0] c_idx_load   = 2'd1;
    localparam logic [1:0] c_idx_value  = 2'd2;
    localparam logic [1:0] c_idx_status = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_wait;
    logic [2:0]  w_wait_nxt;
    logic        w_ready;

    logic        r_en;
    logic        r_auto;
    logic        r_irqen;
    logic [31:0] r_load;
    logic [31:0] r_value;
    logic        r_expired;

    logic        w_en_nxt;
    logic        w_auto_nxt;
    logic        w_irqen_nxt;
    logic [31:0] w_load_nxt;
    logic [31:0] w_value_nxt;
    logic        w_expired_nxt;

    logic [1:0]  w_idx;
    logic        w_addr_bad;
    logic        w_err;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_clr;
    logic        w_expire;
    logic [31:0] w_load_merged;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_unused = &{1'b0, PPROT[2:1]};

    //--------------------------------------------------------------------------
    // Transfer FSM; SETUP is entered at the end of the bus setup cycle, so
    // the first access cycle is evaluated while the register still says SETUP.
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = ST_SETUP;
                    w_wait_nxt  = 3'd0;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = ST_IDLE;
                end else if (!PENABLE) begin
                    w_state_nxt = ST_SETUP;
                    w_wait_nxt  = 3'd0;
                end else if (r_wait == c_wait_last) begin
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                    w_wait_nxt  = r_wait + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset masks completion so a transfer in flight can never commit.
    assign PREADY = w_ready & PRESETn;

    //--------------------------------------------------------------------------
    // Address decode and error classification
    //--------------------------------------------------------------------------
    assign w_idx      = PADDR[3:2];
    assign w_addr_bad = (PADDR[31:4] != 28'd0) || (PADDR[1:0] != 2'd0);
    assign w_err      = w_addr_bad
                     || (PWRITE && (w_idx == c_idx_value))
                     || (PWRITE && (w_idx == c_idx_ctrl) && !PPROT[0]);

    assign w_wr      = PREADY && PWRITE && !w_err;
    assign w_wr_ctrl = w_wr && (w_idx == c_idx_ctrl) && PSTRB[0];
    assign w_wr_load = w_wr && (w_idx == c_idx_load) && (PSTRB != 4'd0);
    assign w_clr     = w_wr && (w_idx == c_idx_status) && PSTRB[0] && PWDATA[0];

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign w_load_merged[8*b +: 8] = PSTRB[b] ? PWDATA[8*b +: 8] : r_load[8*b +: 8];
    end

    //--------------------------------------------------------------------------
    // Timer next state: counter action first, then bus writes override the
    // fields they touch; a same-cycle expiry beats the W1C clear.
    //--------------------------------------------------------------------------
    assign w_expire = r_en && (r_value == 32'd0);

    always_comb begin
        w_en_nxt      = r_en;
        w_auto_nxt    = r_auto;
        w_irqen_nxt   = r_irqen;
        w_load_nxt    = r_load;
        w_value_nxt   = r_value;
        w_expired_nxt = w_expire | (r_expired & ~w_clr);
        if (r_en) begin
            if (r_value != 32'd0) begin
                w_value_nxt = r_value - 32'd1;
            end else if (r_auto) begin
                w_value_nxt = r_load;
            end else begin
                w_en_nxt = 1'b0;
            end
        end
        if (w_wr_ctrl) begin
            w_en_nxt    = PWDATA[0];
            w_auto_nxt  = PWDATA[1];
            w_irqen_nxt = PWDATA[2];
        end
        if (w_wr_load) begin
            w_load_nxt  = w_load_merged;
            w_value_nxt = w_load_merged;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_en      <= 1'b0;
            r_auto    <= 1'b0;
            r_irqen   <= 1'b0;
            r_load    <= 32'd0;
            r_value   <= 32'd0;
            r_expired <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_auto    <= w_auto_nxt;
            r_irqen   <= w_irqen_nxt;
            r_load    <= w_load_nxt;
            r_value   <= w_value_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Read path and response
    //--------------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_idx)
            c_idx_ctrl:   w_rd_mux = {29'd0, r_irqen, r_auto, r_en};
            c_idx_load:   w_rd_mux = r_load;
            c_idx_value:  w_rd_mux = r_value;
            c_idx_status: w_rd_mux = {31'd0, r_expired};
            default:      w_rd_mux = 32'd0;
        endcase
    end

    assign PRDATA  = (PREADY && !PWRITE && !w_err) ? w_rd_mux : 32'd0;
    assign PSLVERR = PREADY && w_err;
    assign IRQ     = r_expired & r_irqen;

endmodule

`default_nettype wire

// File: tb/tb_apb_timer.sv
//==============================================================================
// Module      : tb_apb_timer
// Description : Directed scoreboard bench for apb_timer (WAIT_STATES=2).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apb_timer;

    localparam int WS = 2;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = 32'd0;
    logic [31:0] PWDATA = 32'd0;
    logic [3:0]  PSTRB = 4'd0;
    logic [2:0]  PPROT = 3'd0;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;
    logic        IRQ;

    apb_timer #(.WAIT_STATES(WS)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed transfer.
    initial begin
        int   acc_cnt;
        exp_t e;
        acc_cnt = 0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
            else                 acc_cnt = 0;
            if (PREADY) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_rdata"},   PRDATA,  e.rdata);
                    check({e.name, "_slverr"},  {31'd0, PSLVERR}, {31'd0, e.err});
                    check({e.name, "_latency"}, 32'(acc_cnt), 32'(WS + 1));
                end
            end
        end
    end

    task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   done;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.name  = name;
        q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; PPROT = prot;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge PCLK);
            if (PREADY) done = 1'b1;
            @(posedge PCLK);
        end
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (!done) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            if (q.size() > 0) void'(q.pop_back());
        end
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
        xfer(name, 1'b1, addr, data, 4'hF, 3'b001, 32'd0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        xfer(name, 1'b0, addr, 32'd0, 4'hF, 3'b001, exp, 1'b0);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        @(negedge PCLK);
        check(name, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready",  {31'd0, PREADY},  32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata",  PRDATA,           32'd0);
        check("rst_irq",     {31'd0, IRQ},     32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("post_rst_pready", {31'd0, PREADY}, 32'd0);
        check("post_rst_irq",    {31'd0, IRQ},    32'd0);
        rd("rst_ctrl",   32'h0, 32'd0);
        rd("rst_load",   32'h4, 32'd0);
        rd("rst_value",  32'h8, 32'd0);
        rd("rst_status", 32'hC, 32'd0);

        // Wait-state timing and LOAD->VALUE copy
        wr("ws_load5", 32'h4, 32'h5);
        rd("ws_value5", 32'h8, 32'h5);

        // Auto-reload countdown with interrupt
        wr("ar_load3", 32'h4, 32'h3);
        wr("ar_ctrl7", 32'h0, 32'h7);
        for (int i = 0; i < 4; i++) chk_irq("ar_irq_low", 1'b0);
        chk_irq("ar_irq_high", 1'b1);
        rd("ar_value_reload", 32'h8, 32'h3);
        rd("ar_status", 32'hC, 32'h1);
        wr("ar_stop", 32'h0, 32'h0);

        // One-shot expiry
        wr("os_clr0", 32'hC, 32'h1);
        wr("os_load2", 32'h4, 32'h2);
        wr("os_ctrl1", 32'h0, 32'h1);
        rd("os_ctrl_en0", 32'h0, 32'h0);
        rd("os_value0", 32'h8, 32'h0);
        rd("os_status1", 32'hC, 32'h1);
        chk_irq("os_irq_masked", 1'b0);
        wr("os_irqen", 32'h0, 32'h4);
        chk_irq("os_irq_on", 1'b1);
        wr("os_clr", 32'hC, 32'h1);
        chk_irq("os_irq_off", 1'b0);
        rd("os_status0", 32'hC, 32'h0);

        // Error responses
        xfer("err_wr_value", 1'b1, 32'h8,  32'h55, 4'hF, 3'b001, 32'd0, 1'b1);
        xfer("err_rd_hi",    1'b0, 32'h10, 32'h0,  4'hF, 3'b001, 32'd0, 1'b1);
        xfer("err_ctrl_np",  1'b1, 32'h0,  32'h3,  4'hF, 3'b000, 32'd0, 1'b1);
        xfer("err_misalign", 1'b0, 32'h5,  32'h0,  4'hF, 3'b001, 32'd0, 1'b1);
        rd("err_ctrl_kept",  32'h0, 32'h4);
        rd("err_value_kept", 32'h8, 32'h0);

        // LOAD=0 auto-reload: expiry every cycle beats W1C
        wr("z_load0", 32'h4, 32'h0);
        wr("z_ctrl3", 32'h0, 32'h3);
        wr("z_w1c",   32'hC, 32'h1);
        rd("z_status1", 32'hC, 32'h1);
        rd("z_value0",  32'h8, 32'h0);
        wr("z_stop",  32'h0, 32'h0);

        // W1C landing exactly on the one-shot expiry edge
        wr("c_load4", 32'h4, 32'h4);
        wr("c_ctrl1", 32'h0, 32'h1);
        wr("c_w1c_at_expiry", 32'hC, 32'h1);
        rd("c_status_kept", 32'hC, 32'h1);
        wr("c_w1c", 32'hC, 32'h1);
        rd("c_status_clr", 32'hC, 32'h0);

        // Byte-lane strobes
        wr("s_load_full", 32'h4, 32'h1234_5678);
        xfer("s_load_lane0", 1'b1, 32'h4, 32'h0000_00FF, 4'b0001, 3'b001, 32'd0, 1'b0);
        rd("s_load_merged", 32'h4, 32'h1234_56FF);
        xfer("s_strb0", 1'b1, 32'h4, 32'h0, 4'b0000, 3'b001, 32'd0, 1'b0);
        rd("s_load_noop",  32'h4, 32'h1234_56FF);
        rd("s_value_copy", 32'h8, 32'h1234_56FF);

        // Reset in the middle of an access phase
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF; PPROT = 3'b001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        @(negedge PCLK);
        check("abort_pready_a", {31'd0, PREADY}, 32'd0);
        @(negedge PCLK);
        check("abort_pready_b", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        rd("abort_load0", 32'h4, 32'h0);
        wr("abort_next_wr", 32'h4, 32'hA5);
        rd("abort_next_rd", 32'h4, 32'hA5);

        repeat (5) @(posedge PCLK);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning the number of access-phase cycles with PREADY low before completion (legal 0..7).
REQ-002 SHALL have port PCLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESETn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port PSEL  input  1  completer select.
REQ-005 SHALL have port PENABLE  input  1  access phase indicator.
REQ-006 SHALL have port PWRITE  input  1  1=write, 0=read.
REQ-007 SHALL have port PADDR  input  32  byte address.
REQ-008 SHALL have port PWDATA  input  32  write data.
REQ-009 SHALL have port PSTRB  input  4  write byte-lane enables.
REQ-010 SHALL have port PPROT  input  3  protection; bit0=privileged.
REQ-011 SHALL have port PREADY  output  1  transfer completion.
REQ-012 SHALL have port PSLVERR  output  1  error response, valid only when PREADY=1.
REQ-013 SHALL have port PRDATA  output  32  read data, valid only when PREADY=1 on a read.
REQ-014 SHALL have port IRQ  output  1  timer interrupt, level.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP (PSEL=1, PENABLE=0) -> ACCESS (PSEL=1, PENABLE=1) -> IDLE once PREADY=1; SETUP/ACCESS SHALL return to IDLE if PSEL drops.
REQ-016 In ACCESS, PREADY SHALL stay low for exactly WAIT_STATES cycles, then go high for one cycle; wait counter SHALL reset on entry to SETUP; WAIT_STATES=0 -> PREADY=1 on the first ACCESS cycle.
REQ-017 Register map (PADDR[3:2]): 0x0 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, others read 0); 0x4 LOAD (RW 32b); 0x8 VALUE (RO current count); 0xC STATUS (bit0 EXPIRED, write-1-to-clear).
REQ-018 Writes SHALL commit only on the completion cycle (PSEL & PENABLE & PREADY & PWRITE), byte lanes gated by PSTRB; PSTRB=0000 SHALL be a no-op with PSLVERR=0.
REQ-019 A committed LOAD write SHALL also copy the new LOAD value into VALUE on the same edge.
REQ-020 STATUS writes SHALL clear EXPIRED only when PSTRB[0]=1 and PWDATA[0]=1.
REQ-021 PSLVERR=1 SHALL be driven at completion, with no state change, for: PADDR[31:4]!=0, PADDR[1:0]!=0, write to VALUE, write to CTRL with PPROT[0]=0.
REQ-022 PRDATA SHALL be the addressed register at completion of a legal read and 0 otherwise (including errors and writes).
REQ-023 Counter: when EN=1 and VALUE!=0, VALUE SHALL decrement by 1 each cycle; when EN=0, VALUE SHALL hold.
REQ-024 When EN=1 and VALUE==0: EXPIRED SHALL be set; if AUTORELOAD=1, VALUE<=LOAD, else EN<=0 and VALUE holds 0.
REQ-025 Simultaneous events: expiry SHALL be evaluated on pre-write state; a same-cycle register write SHALL win for the field it writes (EN, VALUE via LOAD); EXPIRED set SHALL win over same-cycle W1C clear.
REQ-026 LOAD=0 with EN=1, AUTORELOAD=1 SHALL set EXPIRED every cycle without wrapping VALUE.
REQ-027 IRQ SHALL equal EXPIRED & IRQEN combinationally from registered state.

Reset
REQ-028 On PCLK edge with PRESETn=0: FSM=IDLE, wait counter=0, CTRL=0, LOAD=0, VALUE=0, EXPIRED=0.
REQ-029 During and immediately after reset: PREADY=0, PSLVERR=0, PRDATA=0, IRQ=0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register update; the next transfer SHALL start from SETUP.

Verification
REQ-031 WAIT_STATES=2, write LOAD=0x0000_0005, PSTRB=1111 -> PREADY high on 3rd ACCESS cycle, PSLVERR=0; read VALUE -> 0x5.
REQ-032 CTRL=0x7 (privileged), LOAD=3 -> VALUE 3,2,1,0, EXPIRED=1 and IRQ=1 on the following edge, VALUE reloads to 3.
REQ-033 CTRL=0x1, LOAD=2 -> VALUE reaches 0, EXPIRED=1, EN reads 0, VALUE stays 0; write STATUS=0x1 -> EXPIRED=0, IRQ=0.
REQ-034 Write VALUE, read PADDR=0x10, write CTRL with PPROT=000 -> each PSLVERR=1, PRDATA=0, CTRL/VALUE unchanged.
REQ-035 W1C to STATUS on the same edge as expiry -> EXPIRED remains 1; write LOAD=0xFF, PSTRB=0001 over LOAD=0x12345678 -> LOAD reads 0x123456FF.
REQ-036 PRESETn=0 during ACCESS of a LOAD write -> LOAD unchanged (0), PREADY=0; next write completes normally.
